// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the instruction register / memory and the multicycle
// control unit. The control unit is the slave; the datapath side is the master.
interface multicycle_control_fsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic       illegal;
    logic       mem_fault;
    logic       retire;
    logic [3:0] state_dbg;

    modport slave (
        input  Op, Funct, mem_ready,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               RegW, MemW, Branch, ImmSrc, RegSrc, illegal, mem_fault,
               retire, state_dbg
    );

    modport master (
        output Op, Funct, mem_ready,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               RegW, MemW, Branch, ImmSrc, RegSrc, illegal, mem_fault,
               retire, state_dbg
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle Moore control unit for the ARM-subset datapath: sequences
// fetch/decode/execute/memory/writeback with a memory wait-state timeout.
module multicycle_control_fsm #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int TIMEOUT       = 15,
    parameter int CNT_W         = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_control_fsm_if.slave     bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;

    logic       w_ready;
    logic       w_mem_state;
    logic       w_timeout;
    logic       w_hold;
    logic       w_unused_funct;

    logic       w_irwrite;
    logic       w_nextpc;
    logic       w_adrsrc;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_resultsrc;
    logic       w_aluop;
    logic       w_regw;
    logic       w_memw;
    logic       w_branch;
    logic       w_illegal;
    logic       w_retire;

    assign w_ready     = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                         (r_state == S_MEMWRITE);
    assign w_timeout   = (TIMEOUT != 0) && w_mem_state && !w_ready && (r_cnt == TO_C);
    // The counter only survives a cycle in which a memory state is held; any
    // transition (including a timeout back to FETCH) restarts it at zero.
    assign w_hold      = w_mem_state && !w_ready && !w_timeout;
    assign w_unused_funct = ^bus.Funct[4:1];

    // State register and wait-state counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_next;
            if (w_hold) begin
                r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= {CNT_W{1'b0}};
            end
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        w_next      = r_state;
        w_irwrite   = 1'b0;
        w_nextpc    = 1'b0;
        w_adrsrc    = 1'b0;
        w_alusrca   = 1'b0;
        w_alusrcb   = 2'b00;
        w_resultsrc = 2'b00;
        w_aluop     = 1'b0;
        w_regw      = 1'b0;
        w_memw      = 1'b0;
        w_branch    = 1'b0;
        w_illegal   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alusrca   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                w_irwrite   = w_ready;
                w_nextpc    = w_ready;
                if (w_ready) begin
                    w_next = S_DECODE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                w_alusrca   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                case (bus.Op)
                    2'b00:   w_next = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrcb = 2'b01;
                w_next    = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adrsrc = 1'b1;
                if (w_ready) begin
                    w_next = S_MEMWB;
                end else if (w_timeout) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regw      = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adrsrc = 1'b1;
                w_memw   = !w_timeout;
                if (w_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_MEMWRITE;
                end
            end
            S_EXECUTER: begin
                w_aluop = 1'b1;
                w_next  = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alusrcb = 2'b01;
                w_aluop   = 1'b1;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regw   = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                w_alusrcb   = 2'b01;
                w_resultsrc = 2'b10;
                w_branch    = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Strobes are suppressed while reset is high so an abandoned instruction
    // never writes anything.
    assign bus.IRWrite   = reset ? 1'b0 : w_irwrite;
    assign bus.NextPC    = reset ? 1'b0 : w_nextpc;
    assign bus.RegW      = reset ? 1'b0 : w_regw;
    assign bus.MemW      = reset ? 1'b0 : w_memw;
    assign bus.Branch    = reset ? 1'b0 : w_branch;
    assign bus.illegal   = reset ? 1'b0 : w_illegal;
    assign bus.mem_fault = reset ? 1'b0 : w_timeout;
    assign bus.retire    = reset ? 1'b0 : w_retire;

    assign bus.AdrSrc    = w_adrsrc;
    assign bus.ALUSrcA   = w_alusrca;
    assign bus.ALUSrcB   = w_alusrcb;
    assign bus.ResultSrc = w_resultsrc;
    assign bus.ALUOp     = w_aluop;
    assign bus.ImmSrc    = bus.Op;
    assign bus.RegSrc    = {(bus.Op == 2'b01), (bus.Op == 2'b10)};
    assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: two control units (handshake on / off) driven with directed
// per-cycle vectors; monitors compare every cycle on the falling clock edge.
module tb_multicycle_control_fsm;

    logic clk;
    logic reset_a;
    logic reset_b;

    multicycle_control_fsm_if ifa ();
    multicycle_control_fsm_if ifb ();

    multicycle_control_fsm #(.MEM_HANDSHAKE(1), .TIMEOUT(15), .CNT_W(4)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (ifa)
    );

    multicycle_control_fsm #(.MEM_HANDSHAKE(0), .TIMEOUT(15), .CNT_W(4)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl vector: {IRWrite,NextPC | AdrSrc,ALUSrcA | ALUSrcB | ResultSrc |
    //               ALUOp,RegW,MemW,Branch | illegal,mem_fault,retire}
    localparam logic [14:0] FULL     = 15'b11_11_11_11_1111_111;
    localparam logic [14:0] STROBES  = 15'b11_00_00_00_0111_111;
    localparam logic [14:0] ZERO     = 15'b00_00_00_00_0000_000;
    localparam logic [14:0] FR       = 15'b11_01_10_10_0000_000;
    localparam logic [14:0] FW       = 15'b00_01_10_10_0000_000;
    localparam logic [14:0] DEC      = 15'b00_01_10_10_0000_000;
    localparam logic [14:0] DEC_ILL  = 15'b00_01_10_10_0000_100;
    localparam logic [14:0] MADR     = 15'b00_00_01_00_0000_000;
    localparam logic [14:0] MRD      = 15'b00_10_00_00_0000_000;
    localparam logic [14:0] MWB      = 15'b00_00_00_01_0100_001;
    localparam logic [14:0] MW_WAIT  = 15'b00_10_00_00_0010_000;
    localparam logic [14:0] MW_RDY   = 15'b00_10_00_00_0010_001;
    localparam logic [14:0] MW_FLT   = 15'b00_10_00_00_0000_010;
    localparam logic [14:0] EXR      = 15'b00_00_00_00_1000_000;
    localparam logic [14:0] EXI      = 15'b00_00_01_00_1000_000;
    localparam logic [14:0] AWB      = 15'b00_00_00_00_0100_001;
    localparam logic [14:0] BRN      = 15'b00_00_01_10_0001_001;

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [14:0] outs;
        logic [14:0] mask;
        logic [3:0]  ext;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    int vectors;
    int miscompares;

    // {ImmSrc, RegSrc} as a function of Op
    function automatic logic [3:0] ext_of(input logic [1:0] op);
        case (op)
            2'b00:   return 4'b00_00;
            2'b01:   return 4'b01_10;
            2'b10:   return 4'b10_01;
            default: return 4'b11_00;
        endcase
    endfunction

    task automatic drv(input bit b, input string nm, input logic rst, input logic [1:0] op,
                       input logic [5:0] fn, input logic rdy, input logic [3:0] st,
                       input logic [14:0] outs, input logic [14:0] mask);
        exp_t e;
        e.name = nm;
        e.st   = st;
        e.outs = outs;
        e.mask = mask;
        e.ext  = ext_of(op);
        if (b) begin
            reset_b = rst; ifb.Op = op; ifb.Funct = fn; ifb.mem_ready = rdy;
            qb.push_back(e);
        end else begin
            reset_a = rst; ifa.Op = op; ifa.Funct = fn; ifa.mem_ready = rdy;
            qa.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic va(input string nm, input logic [1:0] op, input logic [5:0] fn,
                      input logic rdy, input logic [3:0] st, input logic [14:0] outs);
        drv(1'b0, nm, 1'b0, op, fn, rdy, st, outs, FULL);
    endtask

    task automatic vb(input string nm, input logic [1:0] op, input logic [5:0] fn,
                      input logic [3:0] st, input logic [14:0] outs);
        drv(1'b1, nm, 1'b0, op, fn, 1'b0, st, outs, FULL);
    endtask

    task automatic chk(input string tag, input exp_t e, input logic [14:0] act,
                       input logic [3:0] st, input logic [3:0] ext);
        vectors++;
        if ((((act ^ e.outs) & e.mask) !== 15'h0) || (st !== e.st) || (ext !== e.ext)) begin
            miscompares++;
            $display("FAIL %s/%s: got state %0d ctrl %b ext %b, required state %0d ctrl %b (mask %b) ext %b",
                     tag, e.name, st, act, ext, e.st, e.outs, e.mask, e.ext);
        end
    endtask

    // Monitor for the handshaking instance.
    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk("A", ea,
                {ifa.IRWrite, ifa.NextPC, ifa.AdrSrc, ifa.ALUSrcA, ifa.ALUSrcB, ifa.ResultSrc,
                 ifa.ALUOp, ifa.RegW, ifa.MemW, ifa.Branch, ifa.illegal, ifa.mem_fault, ifa.retire},
                ifa.state_dbg, {ifa.ImmSrc, ifa.RegSrc});
        end
    end

    // Monitor for the instance with mem_ready ignored.
    always @(negedge clk) begin
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk("B", eb,
                {ifb.IRWrite, ifb.NextPC, ifb.AdrSrc, ifb.ALUSrcA, ifb.ALUSrcB, ifb.ResultSrc,
                 ifb.ALUOp, ifb.RegW, ifb.MemW, ifb.Branch, ifb.illegal, ifb.mem_fault, ifb.retire},
                ifb.state_dbg, {ifb.ImmSrc, ifb.RegSrc});
        end
    end

    task automatic stim_a();
        drv(1'b0, "rst0", 1'b1, 2'b00, 6'b000000, 1'b1, 4'd0, ZERO, STROBES);
        drv(1'b0, "rst1", 1'b1, 2'b00, 6'b000000, 1'b1, 4'd0, ZERO, STROBES);
        for (int k = 0; k < 2; k++) begin
            va("dpr_fetch", 2'b00, 6'b000000, 1'b1, 4'd0, FR);
            va("dpr_dec",   2'b00, 6'b000000, 1'b1, 4'd1, DEC);
            va("dpr_exe",   2'b00, 6'b000000, 1'b1, 4'd6, EXR);
            va("dpr_wb",    2'b00, 6'b000000, 1'b1, 4'd8, AWB);
        end
        va("dpi_fetch", 2'b00, 6'b100000, 1'b1, 4'd0, FR);
        va("dpi_dec",   2'b00, 6'b100000, 1'b1, 4'd1, DEC);
        va("dpi_exe",   2'b00, 6'b100000, 1'b1, 4'd7, EXI);
        va("dpi_wb",    2'b00, 6'b100000, 1'b1, 4'd8, AWB);
        va("ld_fetch",  2'b01, 6'b000001, 1'b1, 4'd0, FR);
        va("ld_dec",    2'b01, 6'b000001, 1'b1, 4'd1, DEC);
        va("ld_adr",    2'b01, 6'b000001, 1'b0, 4'd2, MADR);
        for (int k = 0; k < 3; k++) va("ld_wait", 2'b01, 6'b000001, 1'b0, 4'd3, MRD);
        va("ld_rd",     2'b01, 6'b000001, 1'b1, 4'd3, MRD);
        va("ld_wb",     2'b01, 6'b000001, 1'b1, 4'd4, MWB);
        va("st_fetch",  2'b01, 6'b000000, 1'b1, 4'd0, FR);
        va("st_dec",    2'b01, 6'b000000, 1'b1, 4'd1, DEC);
        va("st_adr",    2'b01, 6'b000000, 1'b0, 4'd2, MADR);
        for (int k = 0; k < 15; k++) va("st_wait", 2'b01, 6'b000000, 1'b0, 4'd5, MW_WAIT);
        va("st_fault",  2'b01, 6'b000000, 1'b0, 4'd5, MW_FLT);
        va("st2_fetch", 2'b01, 6'b000000, 1'b1, 4'd0, FR);
        va("st2_dec",   2'b01, 6'b000000, 1'b1, 4'd1, DEC);
        va("st2_adr",   2'b01, 6'b000000, 1'b0, 4'd2, MADR);
        for (int k = 0; k < 15; k++) va("st2_wait", 2'b01, 6'b000000, 1'b0, 4'd5, MW_WAIT);
        va("st2_rdy_at_limit", 2'b01, 6'b000000, 1'b1, 4'd5, MW_RDY);
        va("ill_fetch", 2'b11, 6'b000000, 1'b1, 4'd0, FR);
        va("ill_dec",   2'b11, 6'b000000, 1'b1, 4'd1, DEC_ILL);
        va("br_fetch",  2'b10, 6'b000000, 1'b1, 4'd0, FR);
        va("br_dec",    2'b10, 6'b000000, 1'b1, 4'd1, DEC);
        va("br_exe",    2'b10, 6'b000000, 1'b1, 4'd9, BRN);
        va("fw_wait0",  2'b00, 6'b000000, 1'b0, 4'd0, FW);
        va("fw_wait1",  2'b00, 6'b000000, 1'b0, 4'd0, FW);
        va("fw_fetch",  2'b00, 6'b000000, 1'b1, 4'd0, FR);
        va("fw_dec",    2'b00, 6'b000000, 1'b1, 4'd1, DEC);
        va("fw_exe",    2'b00, 6'b000000, 1'b1, 4'd6, EXR);
        va("fw_wb",     2'b00, 6'b000000, 1'b1, 4'd8, AWB);
        va("rs_fetch",  2'b01, 6'b000000, 1'b1, 4'd0, FR);
        va("rs_dec",    2'b01, 6'b000000, 1'b1, 4'd1, DEC);
        va("rs_adr",    2'b01, 6'b000000, 1'b0, 4'd2, MADR);
        va("rs_wait",   2'b01, 6'b000000, 1'b0, 4'd5, MW_WAIT);
        drv(1'b0, "rs_reset", 1'b1, 2'b01, 6'b000000, 1'b0, 4'd5, ZERO, STROBES);
        va("rs_after",  2'b00, 6'b000000, 1'b1, 4'd0, FR);
    endtask

    task automatic stim_b();
        drv(1'b1, "rst0", 1'b1, 2'b10, 6'b000000, 1'b0, 4'd0, ZERO, STROBES);
        drv(1'b1, "rst1", 1'b1, 2'b10, 6'b000000, 1'b0, 4'd0, ZERO, STROBES);
        for (int k = 0; k < 2; k++) begin
            vb("br_fetch", 2'b10, 6'b000000, 4'd0, FR);
            vb("br_dec",   2'b10, 6'b000000, 4'd1, DEC);
            vb("br_exe",   2'b10, 6'b000000, 4'd9, BRN);
        end
        vb("ld_fetch", 2'b01, 6'b000001, 4'd0, FR);
        vb("ld_dec",   2'b01, 6'b000001, 4'd1, DEC);
        vb("ld_adr",   2'b01, 6'b000001, 4'd2, MADR);
        vb("ld_rd",    2'b01, 6'b000001, 4'd3, MRD);
        vb("ld_wb",    2'b01, 6'b000001, 4'd4, MWB);
        vb("st_fetch", 2'b01, 6'b000000, 4'd0, FR);
        vb("st_dec",   2'b01, 6'b000000, 4'd1, DEC);
        vb("st_adr",   2'b01, 6'b000000, 4'd2, MADR);
        vb("st_wr",    2'b01, 6'b000000, 4'd5, MW_RDY);
        vb("end_fetch", 2'b00, 6'b000000, 4'd0, FR);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_a = 1'b1; reset_b = 1'b1;
        ifa.Op = 2'b00; ifa.Funct = 6'b000000; ifa.mem_ready = 1'b1;
        ifb.Op = 2'b00; ifb.Funct = 6'b000000; ifb.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        fork
            stim_a();
            stim_b();
        join
        repeat (2) @(posedge clk);
        if (qa.size() + qb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left unchecked, required 0", qa.size() + qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Next-generation control unit for the ARM-subset datapath. It replaces single-cycle main decoding with a multicycle Moore state machine.
- Sequences Fetch/Decode/Execute/Memory/Writeback per instruction.
- Adds variable-latency memory handshake, a parametrised wait-state timeout, illegal-opcode trapping and a retire pulse.
- Sits between the instruction register (Op, Funct) and the shared-memory multicycle datapath. The ALU decoder consumes ALUOp.

Parameters:
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
- TIMEOUT, 15, maximum wait cycles in any memory state before a fault; 0 disables the timeout.
- CNT_W, 4, width of the wait counter; must hold TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- Op  in  2  instruction [27:26]
- Funct  in  6  instruction [25:20]; Funct[5]=I, Funct[0]=L
- mem_ready  in  1  memory completes the current access this cycle
- IRWrite  out  1  load instruction register
- NextPC  out  1  PC update enable
- AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
- ALUSrcA  out  1  0 = Rn, 1 = PC
- ALUSrcB  out  2  00 = reg, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUOp  out  1  1 = ALU decoder uses Funct
- RegW  out  1  raw register write (before condition logic)
- MemW  out  1  raw memory write
- Branch  out  1  raw branch
- ImmSrc  out  2  equals Op
- RegSrc  out  2  bit0 = (Op==10), bit1 = (Op==01)
- illegal  out  1  one-cycle pulse on Op==11 at DECODE
- mem_fault  out  1  one-cycle pulse on timeout
- retire  out  1  one-cycle pulse in the final state of each instruction
- state_dbg  out  4  current state encoding

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
- Reset: state=FETCH and wait counter=0 on the cycle reset is sampled. All strobes (IRWrite, NextPC, RegW, MemW, Branch, illegal, mem_fault, retire) are 0 while reset is high. Reset mid-instruction abandons the instruction with no writes.
- Unlisted outputs are 0 in every state. "ready" below means mem_ready, or 1 when MEM_HANDSHAKE=0.
- FETCH:
  - Outputs: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - IRWrite=NextPC=ready.
  - Goes to DECODE when ready; otherwise holds.
- DECODE:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - Transitions: Op=00 goes to EXECUTEI if Funct[5] is set, else EXECUTER. Op=01 goes to MEMADR. Op=10 goes to BRANCH. Op=11 pulses illegal and goes to FETCH.
- MEMADR:
  - Outputs: ALUSrcA=0, ALUSrcB=01.
  - Goes to MEMREAD if Funct[0] is set, else MEMWRITE.
- MEMREAD: AdrSrc=1. Holds until ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegW=1, retire=1. Goes to FETCH.
- MEMWRITE:
  - Outputs: AdrSrc=1, ResultSrc=00.
  - MemW=1 for every cycle in the state.
  - When ready: retire=1, goes to FETCH.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1. Goes to ALUWB.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegW=1, retire=1. Goes to FETCH.
- BRANCH:
  - Outputs: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1, retire=1.
  - Goes to FETCH.
- Wait counter:
  - Clears on entry to FETCH, MEMREAD or MEMWRITE. Increments (saturating at 2^CNT_W-1) each cycle a memory state holds without ready.
  - If TIMEOUT>0 and counter==TIMEOUT while still not ready: mem_fault=1, IRWrite/NextPC/MemW are forced to 0 that cycle, state goes to FETCH.
  - ready on the same cycle as the timeout wins: normal transition, no fault.
- Latency with ready tied high: data-processing 4 cycles, load 5, store 4, branch 3.
- Next state is registered; all outputs are a combinational function of state, mem_ready and the counter only. Op/Funct influence only transitions, ImmSrc and RegSrc.

Test Plan:
- Reset held for 2 cycles, then released with ready=1 and Op=00, Funct=000000 -> states 0,1,6,8,0. RegW=1 in ALUWB only. retire pulses once per 4 cycles.
- Load (Op=01, Funct[0]=1) with mem_ready low for 3 cycles in MEMREAD -> state 3 held for 3 extra cycles. ResultSrc=01 and RegW=1 in MEMWB. Total 8 cycles.
- Store (Op=01, Funct=000000) with mem_ready never high, TIMEOUT=15 -> MemW=1 for exactly 15 cycles, one mem_fault pulse, return to FETCH. No retire.
- Op=11 -> illegal pulses for 1 cycle at DECODE, next state FETCH, no RegW/MemW/Branch.
- Branch (Op=10) -> Branch=1 and ALUSrcB=01 in state 9; IRWrite only in FETCH. With MEM_HANDSHAKE=0 and mem_ready=0, total 3 cycles.
- Reset asserted in MEMWRITE with MemW=1 -> MemW=0 in the reset cycle; state 0 on the next edge.
